// File: rtl/rf_wb_buffer.sv
// rf_wb_buffer: register-file writeback buffer with read bypass.
// Queues producer writebacks and drains one per cycle into the RF write port.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_addr/in_data push side;
//   wb_en drain enable; RegWrite/wr_addr/wr_data registered RF write port;
//   fwd_addr1/2 -> fwd_hit1/2, fwd_data1/2 bypass lookups; count/full/empty status.
// Optional: define RF_WB_COALESCE_EN to merge a write into the youngest
//   entry when the addresses match.
module rf_wb_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     wb_en,
   output logic                     RegWrite,
   output logic [AW-1:0]            wr_addr,
   output logic [DW-1:0]            wr_data,
   input  logic [AW-1:0]            fwd_addr1,
   input  logic [AW-1:0]            fwd_addr2,
   output logic                     fwd_hit1,
   output logic [DW-1:0]            fwd_data1,
   output logic                     fwd_hit2,
   output logic [DW-1:0]            fwd_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    ent_addr [DEPTH];
   logic [DW-1:0]    ent_data [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    yng;
   logic [PW-1:0]    fidx;
   logic             pop;
   logic             push;
   logic             coal;
   logic             xfer;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign pop   = wb_en && !empty;
   assign yng   = tail - PW'(1);

`ifdef RF_WB_COALESCE_EN
   // Merge into the youngest entry unless it leaves this very cycle.
   assign coal = in_valid && (in_addr != '0) && ent_vld[yng] &&
                 (ent_addr[yng] == in_addr) &&
                 !((count == CW'(1)) && pop);
   assign in_ready = !full || coal;
`else
   assign coal     = 1'b0;
   assign in_ready = !full;
`endif

   assign xfer = in_valid && in_ready;
   // x0 writes complete the handshake but never occupy an entry.
   assign push = xfer && (in_addr != '0) && !coal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         ent_vld  <= '0;
         RegWrite <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         if (pop) begin
            head          <= head + PW'(1);
            ent_vld[head] <= 1'b0;
            RegWrite      <= 1'b1;
            wr_addr       <= ent_addr[head];
            wr_data       <= ent_data[head];
         end else begin
            RegWrite <= 1'b0;
         end
         if (push) begin
            tail          <= tail + PW'(1);
            ent_vld[tail] <= 1'b1;
         end
         unique case (1'b1)
            push && !pop: count <= count + CW'(1);
            pop && !push: count <= count - CW'(1);
            default:      count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; validity is tracked by ent_vld.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[tail] <= in_addr;
         ent_data[tail] <= in_data;
      end else if (coal) begin
         ent_data[yng] <= in_data;
      end
   end

   // Output stage is checked first, then entries oldest to youngest,
   // so later matches (younger writes) take priority.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      fidx      = '0;
      if (RegWrite && (fwd_addr1 != '0) && (wr_addr == fwd_addr1)) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = wr_data;
      end
      if (RegWrite && (fwd_addr2 != '0) && (wr_addr == fwd_addr2)) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = wr_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         fidx = head + PW'(k);
         if (ent_vld[fidx] && (fwd_addr1 != '0) &&
             (ent_addr[fidx] == fwd_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = ent_data[fidx];
         end
         if (ent_vld[fidx] && (fwd_addr2 != '0) &&
             (ent_addr[fidx] == fwd_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = ent_data[fidx];
         end
      end
   end

endmodule
